// File: rtl/filter2d_seq_if.sv
// Bundled job, kernel-config, engine-control and memory-arbitration signals of the filter2d sequencer.
// master = surrounding system (host, engine, memory); slave = the sequencer.
interface filter2d_seq_if;
  logic        cfg_we;
  logic [1:0]  cfg_set;
  logic [3:0]  cfg_idx;
  logic [7:0]  cfg_data;
  logic        job_valid;
  logic [1:0]  job_set;
  logic        job_ready;
  logic        done;
  logic        err;
  logic        busy;
  logic        f_start;
  logic        f_finish;
  logic        f_hwrite;
  logic [3:0]  f_hidx;
  logic [7:0]  f_hdata;
  logic        f_cs;
  logic        f_we;
  logic [16:0] f_addr;
  logic [7:0]  f_din;
  logic        h_req;
  logic        h_we;
  logic [16:0] h_addr;
  logic [7:0]  h_din;
  logic        h_gnt;
  logic        h_rvalid;
  logic [7:0]  h_dout;
  logic        m_cs;
  logic        m_we;
  logic [16:0] m_addr;
  logic [7:0]  m_din;
  logic [7:0]  m_dout;

  modport master (
    output cfg_we, cfg_set, cfg_idx, cfg_data, job_valid, job_set,
    output f_finish, f_cs, f_we, f_addr, f_din,
    output h_req, h_we, h_addr, h_din, m_dout,
    input  job_ready, done, err, busy, f_start, f_hwrite, f_hidx, f_hdata,
    input  h_gnt, h_rvalid, h_dout, m_cs, m_we, m_addr, m_din
  );

  modport slave (
    input  cfg_we, cfg_set, cfg_idx, cfg_data, job_valid, job_set,
    input  f_finish, f_cs, f_we, f_addr, f_din,
    input  h_req, h_we, h_addr, h_din, m_dout,
    output job_ready, done, err, busy, f_start, f_hwrite, f_hidx, f_hdata,
    output h_gnt, h_rvalid, h_dout, m_cs, m_we, m_addr, m_din
  );
endinterface

// File: rtl/filter2d_seq.sv
// Job sequencer for the filter2d engine: kernel bank, load/start/run/done FSM with timeout,
// and the engine-priority arbiter for the shared 128K x 8 image memory.
module filter2d_seq #(
  parameter int unsigned TIMEOUT_CYC = 786496,
  parameter int unsigned NSETS       = 4
) (
  input logic           clk,
  input logic           rst,
  filter2d_seq_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_DONE} state_t;

  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYC - 1);

  state_t             r_state;
  logic [1:0]         r_set;
  logic [3:0]         r_hidx;
  logic               r_hwrite;
  logic               r_start;
  logic               r_done;
  logic               r_err;
  logic               r_busy;
  logic               r_ready;
  logic [19:0]        r_cnt;
  logic               r_rvalid;
  logic signed [7:0]  r_bank [NSETS][9];

  logic               w_host_ok;
  logic               w_hgnt;

  function automatic logic signed [7:0] kdef(input int unsigned idx);
    if (idx == 4)          return 8'sh20;
    else if (idx[0] == 1'b1) return 8'sh10;
    else                   return 8'sh08;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_set    <= '0;
      r_hidx   <= '0;
      r_hwrite <= 1'b0;
      r_start  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
      for (int s = 0; s < int'(NSETS); s++)
        for (int i = 0; i < 9; i++)
          r_bank[s][i] <= kdef(i);
    end else begin
      // Bank write lands at the edge; the tap on f_hdata this cycle was read before it
      if (bus.cfg_we && (bus.cfg_idx < 4'd9))
        r_bank[bus.cfg_set][bus.cfg_idx] <= bus.cfg_data;
      r_rvalid <= w_hgnt & ~bus.h_we;

      case (r_state)
        S_IDLE: begin
          if (bus.job_valid && r_ready) begin
            r_set    <= bus.job_set;
            r_hidx   <= '0;
            r_hwrite <= 1'b1;
            r_busy   <= 1'b1;
            r_ready  <= 1'b0;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (r_hidx == 4'd8) begin
            r_hwrite <= 1'b0;
            r_hidx   <= '0;
            r_start  <= 1'b1;
            r_state  <= S_START;
          end else begin
            r_hidx <= r_hidx + 4'd1;
          end
        end
        S_START: begin
          r_start <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          // Finish takes precedence over a timeout expiring in the same cycle
          if (bus.f_finish) begin
            r_done  <= 1'b1;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else if (r_cnt == TO_LAST) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_cnt   <= '0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Host is locked out while the engine may own the memory (START/RUN)
  assign w_host_ok = (r_state != S_START) && (r_state != S_RUN);
  assign w_hgnt    = bus.h_req & ~bus.f_cs & w_host_ok;

  always_comb begin
    bus.m_cs   = 1'b0;
    bus.m_we   = 1'b0;
    bus.m_addr = '0;
    bus.m_din  = '0;
    if (bus.f_cs) begin
      bus.m_cs   = 1'b1;
      bus.m_we   = bus.f_we;
      bus.m_addr = bus.f_addr;
      bus.m_din  = bus.f_din;
    end else if (w_hgnt) begin
      bus.m_cs   = 1'b1;
      bus.m_we   = bus.h_we;
      bus.m_addr = bus.h_addr;
      bus.m_din  = bus.h_din;
    end
  end

  assign bus.h_gnt     = w_hgnt;
  assign bus.h_rvalid  = r_rvalid;
  assign bus.h_dout    = r_rvalid ? bus.m_dout : 8'h00;
  assign bus.job_ready = r_ready;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.busy      = r_busy;
  assign bus.f_start   = r_start;
  assign bus.f_hwrite  = r_hwrite;
  assign bus.f_hidx    = r_hidx;
  assign bus.f_hdata   = r_hwrite ? r_bank[r_set][r_hidx] : 8'h00;

endmodule

// File: tb/tb_filter2d_seq.sv
// Directed + randomized bench for filter2d_seq with a kernel-bank / memory reference model.
module tb_filter2d_seq;
  localparam int TO = 100;
  localparam logic [16:0] HW_ADDR = 17'h0_2468;
  localparam logic [7:0]  HW_DAT  = 8'hC3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  filter2d_seq_if bus();
  filter2d_seq #(.TIMEOUT_CYC(TO), .NSETS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_bank [4][9];
  logic [7:0] mem [int];

  int         opt_fin_c, opt_wr_k, opt_wr_idx, opt_rst_c;
  logic [1:0] opt_wr_set;
  logic [7:0] opt_wr_val;
  bit         opt_arb, opt_host_run, opt_hold;

  function automatic logic [7:0] memdef(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {7'h1E, a[16]};
  endfunction

  function automatic logic [7:0] mem_rd(input logic [16:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return memdef(a);
  endfunction

  // Image memory: 1-cycle read latency
  always @(posedge clk) begin
    if (bus.m_cs) begin
      if (bus.m_we) mem[int'(bus.m_addr)] = bus.m_din;
      else          bus.m_dout <= mem_rd(bus.m_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic reset_ref();
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 9; i++)
        ref_bank[s][i] = (i == 4) ? 8'h20 : ((i % 2) == 1 ? 8'h10 : 8'h08);
  endtask

  task automatic defaults();
    opt_fin_c = 19; opt_wr_k = -1; opt_wr_idx = 0; opt_rst_c = -1;
    opt_wr_set = 0; opt_wr_val = 0;
    opt_arb = 0; opt_host_run = 0; opt_hold = 0;
  endtask

  task automatic cfg_write(input logic [1:0] s, input int idx, input logic [7:0] v);
    bus.cfg_we = 1'b1; bus.cfg_set = s; bus.cfg_idx = 4'(idx); bus.cfg_data = v;
    nxt();
    bus.cfg_we = 1'b0;
    if (idx < 9) ref_bank[s][idx] = v;
  endtask

  task automatic host_read(input logic [16:0] a, input logic [7:0] exp);
    bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = a;
    mid();
    chk("hrd_gnt", 32'(bus.h_gnt), 1);
    chk("hrd_maddr", 32'(bus.m_addr), 32'(a));
    chk("hrd_mwe", 32'(bus.m_we), 0);
    nxt();
    bus.h_req = 1'b0;
    mid();
    chk("hrd_rvalid", 32'(bus.h_rvalid), 1);
    chk("hrd_dout", 32'(bus.h_dout), 32'(exp));
    nxt();
    mid();
    chk("hrd_rvalid_off", 32'(bus.h_rvalid), 0);
    nxt();
  endtask

  task automatic run_job(input logic [1:0] set);
    bit exp_err;
    bus.job_valid = 1'b1; bus.job_set = set;
    mid();
    chk("ready_idle", 32'(bus.job_ready), 1);
    nxt();
    if (!opt_hold) bus.job_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k == opt_wr_k) begin
        bus.cfg_we = 1'b1; bus.cfg_set = opt_wr_set;
        bus.cfg_idx = 4'(opt_wr_idx); bus.cfg_data = opt_wr_val;
      end
      if (opt_arb && k == 3) begin
        bus.f_cs = 1'b1; bus.f_we = 1'b1; bus.f_addr = 17'h00123; bus.f_din = 8'h77;
        bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 17'h1ABCD;
      end
      if (opt_arb && k == 4) begin bus.f_cs = 1'b0; bus.f_we = 1'b0; end
      if (opt_arb && k == 5) bus.h_req = 1'b0;
      mid();
      chk("ld_hwrite", 32'(bus.f_hwrite), 1);
      chk("ld_hidx", 32'(bus.f_hidx), 32'(k));
      chk("ld_hdata", 32'(bus.f_hdata), 32'(ref_bank[set][k]));
      chk("ld_busy", 32'(bus.busy), 1);
      chk("ld_ready", 32'(bus.job_ready), 0);
      if (opt_arb && k == 3) begin
        chk("arb_eng_cs", 32'(bus.m_cs), 1);
        chk("arb_eng_we", 32'(bus.m_we), 1);
        chk("arb_eng_addr", 32'(bus.m_addr), 32'h123);
        chk("arb_eng_din", 32'(bus.m_din), 32'h77);
        chk("arb_eng_hgnt", 32'(bus.h_gnt), 0);
      end
      if (opt_arb && k == 4) begin
        chk("arb_host_gnt", 32'(bus.h_gnt), 1);
        chk("arb_host_addr", 32'(bus.m_addr), 32'h1ABCD);
        chk("arb_host_we", 32'(bus.m_we), 0);
      end
      if (opt_arb && k == 5) begin
        chk("arb_rvalid", 32'(bus.h_rvalid), 1);
        chk("arb_dout", 32'(bus.h_dout), 32'(memdef(17'h1ABCD)));
      end
      if (k == opt_wr_k && opt_wr_idx < 9) ref_bank[opt_wr_set][opt_wr_idx] = opt_wr_val;
      nxt();
      bus.cfg_we = 1'b0;
    end
    bus.job_valid = 1'b0;
    mid();
    chk("st_start", 32'(bus.f_start), 1);
    chk("st_hwrite", 32'(bus.f_hwrite), 0);
    nxt();
    for (int c = 0; c < TO; c++) begin
      if (opt_host_run) begin
        bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = HW_ADDR; bus.h_din = HW_DAT;
      end
      bus.f_finish = (c == opt_fin_c);
      if (c == opt_rst_c) rst = 1'b1;
      mid();
      chk("run_done", 32'(bus.done), 0);
      chk("run_busy", 32'(bus.busy), 1);
      chk("run_start", 32'(bus.f_start), 0);
      if (opt_host_run) chk("run_hgnt", 32'(bus.h_gnt), 0);
      nxt();
      bus.f_finish = 1'b0;
      if (c == opt_rst_c) begin
        rst = 1'b0;
        mid();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ready", 32'(bus.job_ready), 1);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_start", 32'(bus.f_start), 0);
        chk("rst_hwrite", 32'(bus.f_hwrite), 0);
        reset_ref();
        nxt();
        mid();
        chk("rst_no_done", 32'(bus.done), 0);
        nxt();
        return;
      end
      if (c == opt_fin_c) break;
    end
    exp_err = !(opt_fin_c >= 0 && opt_fin_c < TO);
    mid();
    chk("dn_done", 32'(bus.done), 1);
    chk("dn_err", 32'(bus.err), 32'(exp_err));
    chk("dn_busy", 32'(bus.busy), 0);
    if (opt_host_run) begin
      chk("dn_hgnt", 32'(bus.h_gnt), 1);
      chk("dn_mwe", 32'(bus.m_we), 1);
      chk("dn_maddr", 32'(bus.m_addr), 32'(HW_ADDR));
    end
    nxt();
    bus.h_req = 1'b0;
    mid();
    chk("post_done", 32'(bus.done), 0);
    chk("post_ready", 32'(bus.job_ready), 1);
    nxt();
  endtask

  initial begin
    bus.cfg_we = 0; bus.cfg_set = 0; bus.cfg_idx = 0; bus.cfg_data = 0;
    bus.job_valid = 0; bus.job_set = 0; bus.f_finish = 0;
    bus.f_cs = 0; bus.f_we = 0; bus.f_addr = 0; bus.f_din = 0;
    bus.h_req = 0; bus.h_we = 0; bus.h_addr = 0; bus.h_din = 0;
    reset_ref();
    defaults();

    rst = 1'b1;
    nxt(); nxt();
    mid();
    chk("rs_ready", 32'(bus.job_ready), 1);
    chk("rs_busy", 32'(bus.busy), 0);
    chk("rs_done", 32'(bus.done), 0);
    chk("rs_start", 32'(bus.f_start), 0);
    chk("rs_hwrite", 32'(bus.f_hwrite), 0);
    chk("rs_mcs", 32'(bus.m_cs), 0);
    nxt();
    rst = 1'b0;

    run_job(2'd0);

    cfg_write(2'd2, 4, 8'h40);
    cfg_write(2'd2, 9, 8'h55);
    run_job(2'd2);

    opt_wr_k = 3; opt_wr_set = 2'd1; opt_wr_idx = 3; opt_wr_val = 8'hA1; opt_hold = 1;
    run_job(2'd1);
    defaults();
    opt_wr_k = 2; opt_wr_set = 2'd1; opt_wr_idx = 6; opt_wr_val = 8'hB2;
    run_job(2'd1);
    defaults();

    host_read(17'h10005, memdef(17'h10005));

    bus.f_finish = 1'b1;
    nxt();
    bus.f_finish = 1'b0;
    mid();
    chk("idle_fin_done", 32'(bus.done), 0);
    chk("idle_fin_busy", 32'(bus.busy), 0);
    nxt();

    opt_host_run = 1; opt_fin_c = 10;
    run_job(2'd3);
    defaults();
    host_read(HW_ADDR, HW_DAT);

    opt_arb = 1;
    run_job(2'd0);
    defaults();

    opt_fin_c = -1;
    run_job(2'd2);
    opt_fin_c = TO - 1;
    run_job(2'd2);
    defaults();

    opt_rst_c = 5;
    run_job(2'd2);
    defaults();
    run_job(2'd2);

    for (int j = 0; j < 6; j++) begin
      cfg_write(2'($urandom_range(0, 3)), $urandom_range(0, 9), 8'($urandom));
      cfg_write(2'($urandom_range(0, 3)), $urandom_range(0, 9), 8'($urandom));
      defaults();
      opt_fin_c = $urandom_range(0, 30);
      if ($urandom_range(0, 1) == 1) begin
        opt_wr_k = $urandom_range(0, 8);
        opt_wr_set = 2'($urandom_range(0, 3));
        opt_wr_idx = $urandom_range(0, 9);
        opt_wr_val = 8'($urandom);
      end
      run_job(2'($urandom_range(0, 3)));
    end
    defaults();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
